// File: rtl/mfp_ahb_gpio_evt.sv
// AHB-Lite GPIO slave: per-bit direction, synchronised inputs, rising/falling
// edge interrupts and an event FIFO of input snapshots behind one IRQ line.
module mfp_ahb_gpio_evt #(
  parameter int unsigned N_CH        = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic [3:0]      HADDR,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic            HSEL,
  input  logic [31:0]     HWDATA,
  output logic [31:0]     HRDATA,
  input  logic [N_CH-1:0] GPIO_IN,
  output logic [N_CH-1:0] GPIO_OUT,
  output logic [N_CH-1:0] GPIO_OE,
  output logic            IRQ
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Registered address phase
  logic [3:0] addr_q;
  logic       wr_q;

  logic [N_CH-1:0] dout_q, dout_d, dir_q, dir_d;
  logic [N_CH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [N_CH-1:0] status_q, status_d, prev_q;
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] mem_q  [FIFO_DEPTH];

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     hrdata_q, hrdata_d, rd_mux;

  logic [N_CH-1:0] din, ev, wdat;
  logic            rd_en, wr_ph, empty, full, pop, push, push_ok;
  logic            unused_hwdata;

  assign wdat          = HWDATA[N_CH-1:0];
  assign unused_hwdata = ^HWDATA;
  assign din           = sync_q[SYNC_STAGES-1];
  assign ev            = (din & ~prev_q & rise_q) | (~din & prev_q & fall_q);
  assign rd_en         = HSEL & ~HWRITE & (HTRANS != 2'b00);
  assign wr_ph         = HSEL &  HWRITE & (HTRANS != 2'b00);
  assign empty         = (cnt_q == '0);
  assign full          = (cnt_q == CntW'(FIFO_DEPTH));
  assign pop           = rd_en & (HADDR == 4'd6) & ~empty;
  assign push          = |ev;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push_ok       = push & (~full | pop);

  assign HRDATA   = hrdata_q;
  assign GPIO_OUT = dout_q;
  assign GPIO_OE  = dir_q;
  assign IRQ      = |(status_q & (rise_q | fall_q));

  // Data-phase register writes, event capture and FIFO bookkeeping
  always_comb begin
    dout_d   = dout_q;
    dir_d    = dir_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    status_d = status_q;
    ovf_d    = ovf_q;
    if (wr_q) begin
      case (addr_q)
        4'd0:    dout_d   = wdat;
        4'd1:    dir_d    = wdat;
        4'd3:    rise_d   = wdat;
        4'd4:    fall_d   = wdat;
        4'd5:    status_d = status_q & ~wdat;
        4'd7:    ovf_d    = 1'b0;
        4'd8:    dout_d   = dout_q | wdat;
        4'd9:    dout_d   = dout_q & ~wdat;
        default: ;
      endcase
    end
    // New events override a simultaneous w1c
    status_d = status_d | ev;
    if (push & full & ~pop) ovf_d = 1'b1;
    wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop     ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q + CntW'(push_ok) - CntW'(pop);
  end

  // Read mux on the address-phase index; reflects pre-write register values
  always_comb begin
    rd_mux = '0;
    case (HADDR)
      4'd0: rd_mux = 32'(dout_q);
      4'd1: rd_mux = 32'(dir_q);
      4'd2: rd_mux = 32'(din);
      4'd3: rd_mux = 32'(rise_q);
      4'd4: rd_mux = 32'(fall_q);
      4'd5: rd_mux = 32'(status_q);
      4'd6: if (!empty) rd_mux = 32'(mem_q[rptr_q]);
      4'd7: begin
        rd_mux[CntW+1:2] = cnt_q;
        rd_mux[1]        = ovf_q;
        rd_mux[0]        = empty;
      end
      default: ;
    endcase
    hrdata_d = rd_en ? rd_mux : hrdata_q;
  end

  // Control and status state with synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q   <= '0;
      wr_q     <= 1'b0;
      dout_q   <= '0;
      dir_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      prev_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      hrdata_q <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      addr_q   <= HADDR;
      wr_q     <= wr_ph;
      dout_q   <= dout_d;
      dir_q    <= dir_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      prev_q   <= din;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      hrdata_q <= hrdata_d;
      sync_q[0] <= GPIO_IN;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // FIFO storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge HCLK) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end

endmodule

// File: tb/tb_mfp_ahb_gpio_evt.sv
// Directed self-checking bench for mfp_ahb_gpio_evt (default parameters).
module tb_mfp_ahb_gpio_evt;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [3:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [15:0] GPIO_IN;
  logic [15:0] GPIO_OUT;
  logic [15:0] GPIO_OE;
  logic        IRQ;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] rd;

  mfp_ahb_gpio_evt #(
    .N_CH       (16),
    .FIFO_DEPTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HSEL    (HSEL),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA),
    .GPIO_IN (GPIO_IN),
    .GPIO_OUT(GPIO_OUT),
    .GPIO_OE (GPIO_OE),
    .IRQ     (IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  // All tasks start and end 1 time unit after a rising edge
  task automatic ahb_wr(input logic [3:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HWDATA = d;
    bus_idle();
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_rd(input logic [3:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    bus_idle();
    d = HRDATA;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge HCLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESET = 1'b1; HADDR = '0; HWDATA = '0; GPIO_IN = '0;
    bus_idle();
    cycles(4);
    HRESET = 1'b0;
    cycles(1);

    // Reset state
    check("rst_oe",  32'(GPIO_OE), 32'h0);
    check("rst_out", 32'(GPIO_OUT), 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);
    for (int i = 0; i < 16; i++) begin
      ahb_rd(4'(i), rd);
      // FIFO_STAT reports empty=1 after reset
      check($sformatf("rst_rd%0d", i), rd, (i == 7) ? 32'h1 : 32'h0);
    end

    // Direction and output writes, set/clear
    ahb_wr(4'd1, 32'h0000_00FF);
    ahb_wr(4'd0, 32'h0000_1234);
    ahb_wr(4'd8, 32'h0000_0001);
    ahb_wr(4'd9, 32'h0000_0030);
    check("oe", 32'(GPIO_OE), 32'h00FF);
    check("out", 32'(GPIO_OUT), 32'h1205);
    ahb_rd(4'd0, rd);
    check("rd_dout", rd, 32'h1205);
    ahb_rd(4'd8, rd);
    check("rd_set0", rd, 32'h0);

    // Back-to-back write then read of DOUT returns pre-write value
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 4'd0;
    @(posedge HCLK); #1;
    HWDATA = 32'h0000_AAAA; HWRITE = 1'b0; HADDR = 4'd0;
    @(posedge HCLK); #1;
    bus_idle();
    check("b2b_rd", HRDATA, 32'h1205);
    check("b2b_out", 32'(GPIO_OUT), 32'hAAAA);

    // Rising edge on bit 0, IRQ latency
    ahb_wr(4'd3, 32'h0000_0001);
    GPIO_IN[0] = 1'b1;
    cycles(1);
    check("irq_e1", 32'(IRQ), 32'h0);
    cycles(1);
    check("irq_e2", 32'(IRQ), 32'h0);
    cycles(1);
    check("irq_e3", 32'(IRQ), 32'h1);
    ahb_rd(4'd5, rd);
    check("status1", rd, 32'h1);
    ahb_rd(4'd7, rd);
    check("fstat1", rd, 32'h4);
    ahb_rd(4'd6, rd);
    check("fdata1", rd, 32'h1);
    ahb_rd(4'd7, rd);
    check("fstat1b", rd, 32'h1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 4'd5;
    @(posedge HCLK); #1;
    HWDATA = 32'h1;
    bus_idle();
    check("irq_pre_w1c", 32'(IRQ), 32'h1);
    @(posedge HCLK); #1;
    check("irq_post_w1c", 32'(IRQ), 32'h0);
    GPIO_IN[0] = 1'b0;
    cycles(4);

    // Both edges on bit 3, ten toggles overflow the FIFO
    ahb_wr(4'd3, 32'h0000_FFFF);
    ahb_wr(4'd4, 32'h0000_FFFF);
    for (int i = 0; i < 10; i++) begin
      GPIO_IN[3] = ~GPIO_IN[3];
      cycles(1);
    end
    cycles(4);
    check("ovf_irq", 32'(IRQ), 32'h1);
    ahb_rd(4'd7, rd);
    check("ovf_stat", rd, 32'h22);
    ahb_rd(4'd6, rd);
    check("ovf_first", rd, 32'h8);
    ahb_wr(4'd7, 32'h0);
    ahb_rd(4'd7, rd);
    check("ovf_clr", rd, 32'h1C);

    // Refill to full: FIFO holds 0,8,0,8,0,8,0 then push 8
    GPIO_IN[3] = 1'b1;
    cycles(4);
    ahb_rd(4'd7, rd);
    check("full_stat", rd, 32'h20);

    // Pop and push on the same edge while full
    GPIO_IN[3] = 1'b0;
    cycles(2);
    ahb_rd(4'd6, rd);
    check("pp_data", rd, 32'h0);
    ahb_rd(4'd7, rd);
    check("pp_stat", rd, 32'h20);
    ahb_rd(4'd6, rd);
    check("pp_next", rd, 32'h8);

    // Drain: remaining 0,8,0,8,0,8,0
    for (int i = 0; i < 7; i++) begin
      ahb_rd(4'd6, rd);
      check($sformatf("drain%0d", i), rd, (i % 2 == 0) ? 32'h0 : 32'h8);
    end
    ahb_rd(4'd7, rd);
    check("empty_stat", rd, 32'h1);
    ahb_rd(4'd0, rd);
    check("pre_empty", rd, 32'hAAAA);
    ahb_rd(4'd6, rd);
    check("empty_pop", rd, 32'h0);
    ahb_rd(4'd7, rd);
    check("empty_stat2", rd, 32'h1);

    // w1c of bit 2 coincides with a new rising event on bit 2
    GPIO_IN[2] = 1'b1;
    cycles(1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 4'd5;
    @(posedge HCLK); #1;
    HWDATA = 32'h4;
    bus_idle();
    @(posedge HCLK); #1;
    check("w1c_irq", 32'(IRQ), 32'h1);
    ahb_rd(4'd5, rd);
    check("w1c_status", rd, 32'h000C);
    ahb_wr(4'd5, 32'h0000_FFFF);
    check("clr_irq", 32'(IRQ), 32'h0);
    ahb_rd(4'd5, rd);
    check("clr_status", rd, 32'h0);
    ahb_rd(4'd2, rd);
    check("din", rd, 32'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
